// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared widths, FSM encoding and request record for the SDRAM host bridge
package sdram_pkg;

  localparam int HADDR_WIDTH_DEF = 24;
  localparam int DATA_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  typedef struct packed {
    logic                       we;
    logic [HADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_W-1:0]          wdata;
  } sdram_req_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// rtl/sdram_req_fifo.sv - power-of-two request queue with push/pop, full/empty and occupancy count
module sdram_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sdram_host_bridge.sv
// rtl/sdram_host_bridge.sv - queues host requests and issues them one at a time to an SDRAM controller
module sdram_host_bridge
  import sdram_pkg::*;
#(
  parameter int HADDR_WIDTH = HADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   wr_enable,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_enable,
  input  logic [DATA_W-1:0]      rd_data,
  input  logic                   rd_ready,
  input  logic                   busy,
  output logic                   idle
);
  localparam int REQ_W = 1 + HADDR_WIDTH + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e                 state_q, state_d;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0]       fifo_rdata;
  logic [CNT_W-1:0]       fifo_count;
  logic                   head_we;
  logic [HADDR_WIDTH-1:0] head_addr;
  logic [DATA_W-1:0]      head_wdata;

  logic                   cmd_we_q, cmd_we_d;
  logic [HADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]      cmd_wdata_q, cmd_wdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign {head_we, head_addr, head_wdata} = fifo_rdata;

  sdram_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ({req_we, req_addr, req_wdata}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    case (state_q)
      // A pending response blocks issue so responses return in request order.
      ST_IDLE: begin
        if (!fifo_empty && !busy && !rsp_valid_q) begin
          fifo_pop    = 1'b1;
          cmd_we_d    = head_we;
          cmd_addr_d  = head_addr;
          cmd_wdata_d = head_wdata;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: if (busy) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (cmd_we_q) begin
          if (!busy) state_d = ST_IDLE;
        end else if (rd_ready) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rsp_data_d  = rd_data;
        rsp_valid_d = 1'b1;
        state_d     = ST_DRAIN;
      end
      ST_DRAIN: if (!busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign wr_enable = (state_q == ST_ISSUE) && cmd_we_q;
  assign rd_enable = (state_q == ST_ISSUE) && !cmd_we_q;
  assign wr_addr   = cmd_addr_q;
  assign rd_addr   = cmd_addr_q;
  assign wr_data   = cmd_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = (fifo_count == '0) && (state_q == ST_IDLE) && !busy;

endmodule

// File: tb/tb_sdram_host_bridge.sv
// tb/tb_sdram_host_bridge.sv - vector table plus corner sequences against a cycle-level controller model
module tb_sdram_host_bridge;
  import sdram_pkg::*;

  localparam int M_IDLE = 0, M_WAIT = 1, M_BUSY = 2, M_RDY = 3, M_TAIL = 4;
  localparam int NV = 10;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [23:0] wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic        wr_enable, rd_enable, rd_ready, busy, idle;

  sdram_host_bridge #(.HADDR_WIDTH(24), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data),
    .rd_ready(rd_ready), .busy(busy), .idle(idle)
  );

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    int          delay;
    int          dur;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t vt [NV];

  int n_vec = 0, n_mis = 0;
  int cyc = 0;
  sdram_req_t  exp_cmd_q [$];
  logic [15:0] exp_rsp_q [$];
  logic [15:0] mem [logic [23:0]];

  int cfg_delay = 0, cfg_dur = 1, cfg_tail = 1;
  logic hold_busy = 1'b0, m_busy = 1'b0, m_abort = 1'b0;
  int m_phase = M_IDLE, m_wait = 0, m_cnt = 0, m_en_hi = 0;
  logic m_we = 1'b0;
  logic [23:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic en_prev = 1'b0, rsp_prev = 1'b0;
  int en_rise = 0, rise_cyc = 0, hs_cyc = 0, rdy_fall_cyc = 0, rsp_rise_cyc = 0, rsp_rises = 0;
  int en_err = 0, excl_err = 0, drop_err = 0, stab_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // Controller model and response monitor, both stepped on the falling edge.
  task automatic model_step();
    logic en;
    sdram_req_t e;
    en = wr_enable | rd_enable;
    if (wr_enable && rd_enable) excl_err++;
    if (en && !en_prev) begin en_rise++; rise_cyc = cyc; end
    en_prev = en;
    if (req_valid && req_ready) hs_cyc = cyc;
    if (rsp_valid && !rsp_prev) begin rsp_rises++; rsp_rise_cyc = cyc; end
    rsp_prev = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (exp_rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_data", rsp_data, exp_rsp_q.pop_front());
    end
    if (m_phase == M_IDLE && en) begin
      m_we = wr_enable;
      m_addr = wr_enable ? wr_addr : rd_addr;
      m_wdata = wr_data;
      m_abort = 1'b0;
      check("addr_mirror", rd_addr, wr_addr);
      if (exp_cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
      else begin
        e = exp_cmd_q.pop_front();
        check("cmd_we", m_we, e.we);
        check("cmd_addr", m_addr, e.addr);
        if (e.we) check("cmd_wdata", m_wdata, e.wdata);
      end
      if (m_we) mem[m_addr] = m_wdata;
      m_en_hi = 0;
      m_wait = cfg_delay;
      m_phase = M_WAIT;
    end
    if (m_phase == M_WAIT) begin
      if (!en) drop_err++;
      m_en_hi++;
      if (m_wait == 0) begin m_busy = 1'b1; m_phase = M_BUSY; m_cnt = cfg_dur; end
      else m_wait--;
    end else if (m_phase != M_IDLE) begin
      if (en) en_err++;
      if (!rst && !m_abort && wr_addr !== m_addr) stab_err++;
      if (m_phase == M_BUSY) begin
        if (m_cnt > 0) m_cnt--;
        else if (m_we) begin m_busy = 1'b0; m_phase = M_IDLE; end
        else begin
          rd_ready = 1'b1;
          rd_data = mem.exists(m_addr) ? mem[m_addr] : 16'h0000;
          m_phase = M_RDY;
        end
      end else if (m_phase == M_RDY) begin
        rd_ready = 1'b0;
        rdy_fall_cyc = cyc;
        m_cnt = cfg_tail;
        m_phase = M_TAIL;
      end else begin
        if (m_cnt > 0) m_cnt--;
        else begin m_busy = 1'b0; m_phase = M_IDLE; end
      end
    end
    busy = m_busy | hold_busy;
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic push_req(input logic we, input logic [23:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, output int acc_cyc);
    bit ok;
    sdram_req_t e;
    ok = 1'b0;
    acc_cyc = 0;
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    check("req_accept", ok, 1);
    if (ok) begin
      acc_cyc = cyc;
      e.we = we; e.addr = a; e.wdata = d;
      exp_cmd_q.push_back(e);
      if (!we) exp_rsp_q.push_back(exp_rd);
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (idle && !rsp_valid && exp_cmd_q.size() == 0) begin ok = 1'b1; break; end
    end
    check("idle_reached", ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_mis++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    int acc, rel_cyc, r0, v0;
    bit ok;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; busy = 1'b0; rd_ready = 1'b0; rd_data = '0;

    vt[0] = '{1'b1, 24'h012345, 16'hBEEF, 0, 2, 16'h0000};
    vt[1] = '{1'b1, 24'h000010, 16'hBEEF, 0, 1, 16'h0000};
    vt[2] = '{1'b0, 24'h000010, 16'hDEAD, 0, 3, 16'hBEEF};
    vt[3] = '{1'b1, 24'hFFFFFF, 16'h1234, 3, 0, 16'h0000};
    vt[4] = '{1'b0, 24'hFFFFFF, 16'hDEAD, 2, 4, 16'h1234};
    vt[5] = '{1'b1, 24'h000000, 16'h0000, 0, 0, 16'h0000};
    vt[6] = '{1'b0, 24'h000000, 16'hDEAD, 0, 0, 16'h0000};
    vt[7] = '{1'b1, 24'h000010, 16'hA5A5, 1, 2, 16'h0000};
    vt[8] = '{1'b0, 24'h000010, 16'hDEAD, 0, 1, 16'hA5A5};
    vt[9] = '{1'b0, 24'h012345, 16'hDEAD, 5, 2, 16'hBEEF};

    repeat (3) @(posedge clk); #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_wr_enable", wr_enable, 0);
    check("rst_rd_enable", rd_enable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cfg_delay = vt[i].delay;
      cfg_dur = vt[i].dur;
      r0 = en_rise;
      push_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rd, acc);
      wait_idle(300);
      check("latency", rise_cyc - hs_cyc, 2);
      check("one_cmd", en_rise - r0, 1);
      if (!vt[i].we) check("rsp_after_rdy_fall", rsp_rise_cyc - rdy_fall_cyc, 1);
    end
    cfg_delay = 0; cfg_dur = 1;

    // Queue fills while the controller is held busy; fifth request waits for a free entry.
    r0 = en_rise;
    @(posedge clk); #2; hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_req(1'b1, 24'h000200 + 24'(i), 16'h1000 + 16'(i), 16'h0, acc);
    @(negedge clk);
    check("full_ready_low", req_ready, 0);
    check("full_not_idle", idle, 0);
    rel_cyc = 0;
    fork
      push_req(1'b0, 24'h000202, 16'hDEAD, 16'h1002, acc);
      begin repeat (6) @(posedge clk); #2; hold_busy = 1'b0; rel_cyc = cyc; end
    join
    check("fifth_after_release", acc > rel_cyc, 1);
    wait_idle(400);
    check("five_cmds", en_rise - r0, 5);

    // Second read must not issue while the first response is unconsumed.
    r0 = en_rise;
    @(posedge clk); #2; rsp_ready = 1'b0;
    push_req(1'b0, 24'h000010, 16'hDEAD, 16'hA5A5, acc);
    push_req(1'b0, 24'h012345, 16'hDEAD, 16'hBEEF, acc);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    check("rsp_wait", ok, 1);
    repeat (20) @(negedge clk);
    check("rd2_blocked", en_rise - r0, 1);
    check("rsp_held_valid", rsp_valid, 1);
    check("rsp_held_data", rsp_data, 16'hA5A5);
    @(posedge clk); #2; rsp_ready = 1'b1;
    wait_idle(300);
    check("rd2_issued", en_rise - r0, 2);

    // Refresh: busy stays low for 12 cycles after the enable.
    r0 = en_rise;
    cfg_delay = 12;
    push_req(1'b1, 24'h000300, 16'h5A5A, 16'h0, acc);
    wait_idle(300);
    check("refresh_en_cycles", m_en_hi, 13);
    check("refresh_one_cmd", en_rise - r0, 1);
    cfg_delay = 0;

    // Reset while a read is active and two writes are queued.
    cfg_dur = 10;
    push_req(1'b0, 24'h000202, 16'hDEAD, 16'h1002, acc);
    push_req(1'b1, 24'h000400, 16'h7777, 16'h0, acc);
    push_req(1'b1, 24'h000401, 16'h8888, 16'h0, acc);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (m_phase == M_BUSY && !m_we) begin ok = 1'b1; break; end
    end
    check("read_active", ok, 1);
    @(posedge clk); #2;
    m_abort = 1'b1;
    rst = 1'b1;
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    #1;
    check("mid_rst_wr_enable", wr_enable, 0);
    check("mid_rst_rd_enable", rd_enable, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_req_ready", req_ready, 1);
    repeat (2) @(posedge clk); #2;
    rst = 1'b0;
    cfg_dur = 1;
    r0 = en_rise;
    v0 = rsp_rises;
    repeat (40) @(negedge clk);
    check("post_rst_no_cmd", en_rise - r0, 0);
    check("post_rst_no_rsp", rsp_rises - v0, 0);
    check("post_rst_idle", idle, 1);

    // Bridge works after reset, and the discarded write never reached memory.
    push_req(1'b0, 24'h000300, 16'hDEAD, 16'h5A5A, acc);
    wait_idle(300);
    check("post_rst_latency", rise_cyc - hs_cyc, 2);
    push_req(1'b0, 24'h000400, 16'hDEAD, 16'h0000, acc);
    wait_idle(300);

    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("rsp_queue_drained", exp_rsp_q.size(), 0);
    check("enable_exclusive", excl_err, 0);
    check("enable_low_after_busy", en_err, 0);
    check("enable_held_until_busy", drop_err, 0);
    check("addr_stable", stab_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
